// File: rtl/sensor_poll_scheduler_if.sv
// ---------------------------------------------------------------------------
// sensor_poll_scheduler_if
// Groups the scheduling controls and the shared acquisition-bus handshake of
// sensor_poll_scheduler.
//   ENABLE       global scheduling enable
//   PERIOD_US    packed per-channel periods in us, channel i at [i*PER_W +: PER_W]
//   DONE         pulse: granted channel finished its bus access
//   CLEAR_FLAGS  pulse: clears OVERRUN and TIMEOUT
//   GRANT        one-hot bus grant, held for the whole access
//   START        one-hot pulse in the first GRANT cycle
//   OVERRUN      sticky per-channel overrun flags
//   TIMEOUT      sticky per-channel DONE-timeout flags
// master: the scheduler (owns GRANT/START/flags); slave: the environment.
// ---------------------------------------------------------------------------
interface sensor_poll_scheduler_if #(
    parameter int NUM_CH = 3,
    parameter int PER_W  = 16
);
    logic                      ENABLE;
    logic [NUM_CH*PER_W-1:0]   PERIOD_US;
    logic                      DONE;
    logic                      CLEAR_FLAGS;
    logic [NUM_CH-1:0]         GRANT;
    logic [NUM_CH-1:0]         START;
    logic [NUM_CH-1:0]         OVERRUN;
    logic [NUM_CH-1:0]         TIMEOUT;

    modport master (
        input  ENABLE, PERIOD_US, DONE, CLEAR_FLAGS,
        output GRANT, START, OVERRUN, TIMEOUT
    );

    modport slave (
        output ENABLE, PERIOD_US, DONE, CLEAR_FLAGS,
        input  GRANT, START, OVERRUN, TIMEOUT
    );
endinterface

// File: rtl/sensor_poll_scheduler.sv
// ---------------------------------------------------------------------------
// sensor_poll_scheduler
// Generates periodic sample requests for NUM_CH sensor channels from a 1 MHz
// tick and arbitrates the single acquisition bus round-robin with a
// GRANT/START/DONE handshake and a DONE timeout. Runs in the 26 MHz domain.
//   CLK_26MHZ_IN  system clock
//   RESET         asynchronous active-low reset
//   CLK_1MHZ_IN   1 MHz square wave from the divider (sampled here)
//   bus           scheduler side (master modport) of sensor_poll_scheduler_if
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module sensor_poll_scheduler #(
    parameter int NUM_CH = 3,
    parameter int PER_W  = 16,
    parameter int TMO_US = 200
) (
    input  logic                     CLK_26MHZ_IN,
    input  logic                     RESET,
    input  logic                     CLK_1MHZ_IN,
    sensor_poll_scheduler_if.master  bus
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = $clog2(TMO_US + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic                           clk1_cur_q, clk1_cur_d;
    logic                           clk1_prev_q, clk1_prev_d;
    logic [NUM_CH-1:0][PER_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]              pend_q, pend_d;
    logic [IDX_W-1:0]               last_q, last_d;
    logic [IDX_W-1:0]               sel_q, sel_d;
    logic [TMO_W-1:0]               tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CH-1:0]              grant_q, grant_d;
    logic [NUM_CH-1:0]              start_q, start_d;
    logic [NUM_CH-1:0]              ovr_q, ovr_d;
    logic [NUM_CH-1:0]              tmo_flag_q, tmo_flag_d;

    logic                           tick_s;
    logic [NUM_CH-1:0]              due_s;
    logic [NUM_CH-1:0]              issue_s;
    logic [NUM_CH-1:0]              ovr_set_s;
    logic [NUM_CH-1:0]              tmo_set_s;

    function automatic logic [PER_W-1:0] ch_period(input logic [NUM_CH*PER_W-1:0] vec,
                                                   input int ch);
        ch_period = vec[ch*PER_W +: PER_W];
    endfunction

    function automatic logic [NUM_CH-1:0] one_hot(input logic [IDX_W-1:0] idx);
        one_hot      = '0;
        one_hot[idx] = 1'b1;
    endfunction

    // First requesting channel strictly after 'last', wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [IDX_W-1:0]  last);
        logic [IDX_W:0] idx;
        logic           found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = {1'b0, last} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_CH)) begin
                idx = idx - (IDX_W+1)'(NUM_CH);
            end else begin
                idx = idx;
            end
            if (!found && req[idx[IDX_W-1:0]]) begin
                rr_pick = idx[IDX_W-1:0];
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // Rising-edge detect on the sampled 1 MHz wave: one cycle per microsecond.
    always_comb begin
        clk1_cur_d  = CLK_1MHZ_IN;
        clk1_prev_d = clk1_cur_q;
        tick_s      = clk1_cur_q & ~clk1_prev_q;
    end

    // Period counters, pending requests and overrun detection.
    always_comb begin
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        due_s     = '0;
        issue_s   = (state_q == ST_ISSUE) ? grant_q : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!bus.ENABLE || (ch_period(bus.PERIOD_US, i) == '0)) begin
                cnt_d[i] = '0;
            end else if (tick_s) begin
                // '>=' also catches a period shrunk below the running count.
                if (cnt_q[i] >= ch_period(bus.PERIOD_US, i) - PER_W'(1)) begin
                    cnt_d[i] = '0;
                    due_s[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + PER_W'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end

            if (!bus.ENABLE || (ch_period(bus.PERIOD_US, i) == '0)) begin
                pend_d[i] = 1'b0;
            end else if (due_s[i]) begin
                pend_d[i] = 1'b1;   // a due coinciding with its own issue re-arms
            end else if (issue_s[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
        ovr_set_s = due_s & pend_q & ~issue_s;
    end

    // Arbiter next state, grant/start outputs and DONE timeout.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        start_d   = '0;
        sel_d     = sel_q;
        last_d    = last_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_set_s = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ENABLE && (|pend_q)) begin
                    sel_d   = rr_pick(pend_q, last_q);
                    grant_d = one_hot(sel_d);
                    start_d = one_hot(sel_d);
                    state_d = ST_ISSUE;
                end else begin
                    grant_d = '0;
                end
            end
            ST_ISSUE: begin
                last_d    = sel_q;
                tmo_cnt_d = '0;
                state_d   = ST_BUSY;
            end
            ST_BUSY: begin
                // DONE wins over a timeout expiring in the same cycle.
                if (bus.DONE) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end else if (tick_s && (tmo_cnt_q == TMO_W'(TMO_US - 1))) begin
                    tmo_set_s = grant_q;
                    grant_d   = '0;
                    state_d   = ST_RELEASE;
                end else if (tick_s) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end else begin
                    tmo_cnt_d = tmo_cnt_q;
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Sticky flags: a new set beats a simultaneous clear.
        ovr_d      = (ovr_q      & ~{NUM_CH{bus.CLEAR_FLAGS}}) | ovr_set_s;
        tmo_flag_d = (tmo_flag_q & ~{NUM_CH{bus.CLEAR_FLAGS}}) | tmo_set_s;
    end

    // State and output registers.
    always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            clk1_cur_q  <= 1'b1;
            clk1_prev_q <= 1'b1;
            cnt_q       <= '0;
            pend_q      <= '0;
            last_q      <= IDX_W'(NUM_CH - 1);
            sel_q       <= '0;
            tmo_cnt_q   <= '0;
            grant_q     <= '0;
            start_q     <= '0;
            ovr_q       <= '0;
            tmo_flag_q  <= '0;
        end else begin
            state_q     <= state_d;
            clk1_cur_q  <= clk1_cur_d;
            clk1_prev_q <= clk1_prev_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            tmo_cnt_q   <= tmo_cnt_d;
            grant_q     <= grant_d;
            start_q     <= start_d;
            ovr_q       <= ovr_d;
            tmo_flag_q  <= tmo_flag_d;
        end
    end

    assign bus.GRANT   = grant_q;
    assign bus.START   = start_q;
    assign bus.OVERRUN = ovr_q;
    assign bus.TIMEOUT = tmo_flag_q;
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler. The 1 MHz wave rises at times
// 140+260k, so the DUT's tick falls in cycle 15+26k (cycle j spans the
// posedge at 10j-5 to the next; 'cyc' equals j at its negedge).
module tb_sensor_poll_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic clk1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   ft;
    int   s;
    logic seen_start;

    sensor_poll_scheduler_if #(.NUM_CH(3), .PER_W(16)) bus_if ();

    sensor_poll_scheduler #(.NUM_CH(3), .PER_W(16), .TMO_US(200)) dut (
        .CLK_26MHZ_IN (clk),
        .RESET        (rst_n),
        .CLK_1MHZ_IN  (clk1),
        .bus          (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        clk1 = 1'b0;
        #10;
        forever begin
            #130 clk1 = 1'b1;
            #130 clk1 = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_tick(input int c);
        if (c <= 15) return 15;
        return 15 + 26 * ((c - 15 + 25) / 26);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_start(input logic [2:0] exp, input int exp_cyc, input string tag);
        int budget;
        budget = exp_cyc - cyc + 8;
        for (int i = 0; i < budget && bus_if.START == 3'b000; i++) @(negedge clk);
        check({tag, " start"}, {29'd0, bus_if.START}, {29'd0, exp});
        check({tag, " cycle"}, cyc, exp_cyc);
    endtask

    task automatic do_done(input logic [2:0] g, input string tag);
        @(negedge clk);
        check({tag, " busy grant"}, {29'd0, bus_if.GRANT}, {29'd0, g});
        check({tag, " start pulse"}, {29'd0, bus_if.START}, 32'd0);
        bus_if.DONE = 1'b1;
        @(negedge clk);
        bus_if.DONE = 1'b0;
        check({tag, " release"}, {29'd0, bus_if.GRANT}, 32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus_if.ENABLE      = 1'b1;
        bus_if.PERIOD_US   = {16'd0, 16'd25, 16'd10};
        bus_if.DONE        = 1'b0;
        bus_if.CLEAR_FLAGS = 1'b0;
        @(negedge clk);
        check("reset grant",   {29'd0, bus_if.GRANT},   32'd0);
        check("reset start",   {29'd0, bus_if.START},   32'd0);
        check("reset overrun", {29'd0, bus_if.OVERRUN}, 32'd0);
        check("reset timeout", {29'd0, bus_if.TIMEOUT}, 32'd0);
        wait_until(3);
        rst_n = 1'b1;

        // Periods 10/25: tick N falls in cycle 15+26(N-1), START two cycles later.
        expect_start(3'b001, 251, "t10 ch0");   do_done(3'b001, "t10 ch0");
        expect_start(3'b001, 511, "t20 ch0");   do_done(3'b001, "t20 ch0");
        expect_start(3'b010, 641, "t25 ch1");   do_done(3'b010, "t25 ch1");
        expect_start(3'b001, 771, "t30 ch0");   do_done(3'b001, "t30 ch0");
        expect_start(3'b001, 1031, "t40 ch0");  do_done(3'b001, "t40 ch0");
        // Both due at tick 50; last grant was ch0 so ch1 goes first.
        expect_start(3'b010, 1291, "t50 rr ch1"); do_done(3'b010, "t50 rr ch1");
        expect_start(3'b001, 1295, "t50 rr ch0"); do_done(3'b001, "t50 rr ch0");
        check("no overrun yet", {29'd0, bus_if.OVERRUN}, 32'd0);

        // ch0 alone; DONE withheld -> overrun at tick 80, timeout at tick 260.
        bus_if.PERIOD_US = {16'd0, 16'd0, 16'd10};
        expect_start(3'b001, 1551, "t60 ch0");
        wait_until(2069);
        check("overrun before", {29'd0, bus_if.OVERRUN}, 32'd0);
        wait_until(2070);
        check("overrun set", {29'd0, bus_if.OVERRUN}, 32'd1);
        wait_until(6749);
        check("grant before tmo", {29'd0, bus_if.GRANT},   32'd1);
        check("timeout before",   {29'd0, bus_if.TIMEOUT}, 32'd0);
        wait_until(6750);
        check("grant after tmo", {29'd0, bus_if.GRANT},   32'd0);
        check("timeout set",     {29'd0, bus_if.TIMEOUT}, 32'd1);
        expect_start(3'b001, 6752, "regrant ch0"); do_done(3'b001, "regrant ch0");
        wait_until(6755);
        bus_if.CLEAR_FLAGS = 1'b1;
        wait_until(6756);
        bus_if.CLEAR_FLAGS = 1'b0;
        check("clear overrun", {29'd0, bus_if.OVERRUN}, 32'd0);
        check("clear timeout", {29'd0, bus_if.TIMEOUT}, 32'd0);

        // Overrun set at tick 290 with a coincident clear; then DONE on expiry (tick 470).
        expect_start(3'b001, 7011, "t270 ch0");
        wait_until(7529);
        check("overrun pre set-wins", {29'd0, bus_if.OVERRUN}, 32'd0);
        bus_if.CLEAR_FLAGS = 1'b1;
        wait_until(7530);
        bus_if.CLEAR_FLAGS = 1'b0;
        check("set beats clear", {29'd0, bus_if.OVERRUN}, 32'd1);
        wait_until(12209);
        check("grant at expiry", {29'd0, bus_if.GRANT}, 32'd1);
        bus_if.DONE = 1'b1;
        wait_until(12210);
        bus_if.DONE = 1'b0;
        check("release on done", {29'd0, bus_if.GRANT},   32'd0);
        check("no timeout",      {29'd0, bus_if.TIMEOUT}, 32'd0);
        expect_start(3'b001, 12212, "after expiry ch0"); do_done(3'b001, "after expiry ch0");
        wait_until(12216);
        bus_if.DONE = 1'b1;
        wait_until(12217);
        bus_if.DONE = 1'b0;
        wait_until(12219);
        check("stray done grant", {29'd0, bus_if.GRANT}, 32'd0);
        check("stray done start", {29'd0, bus_if.START}, 32'd0);
        expect_start(3'b001, 12471, "t480 ch0");

        // ENABLE dropped mid-BUSY: access still ends on DONE, then silence.
        @(negedge clk);
        bus_if.ENABLE = 1'b0;
        do_done(3'b001, "disabled busy");
        seen_start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus_if.START != 3'b000) seen_start = 1'b1;
        end
        check("no start disabled", {31'd0, seen_start}, 32'd0);
        wait_until(13100);
        bus_if.ENABLE = 1'b1;
        ft = next_tick(13100);
        expect_start(3'b001, ft + 26 * 9 + 2, "reenable ch0");
        s = cyc;

        // Asynchronous reset in BUSY.
        @(negedge clk);
        check("busy before reset",    {29'd0, bus_if.GRANT},   32'd1);
        check("overrun before reset", {29'd0, bus_if.OVERRUN}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async grant",   {29'd0, bus_if.GRANT},   32'd0);
        check("async start",   {29'd0, bus_if.START},   32'd0);
        check("async overrun", {29'd0, bus_if.OVERRUN}, 32'd0);
        check("async timeout", {29'd0, bus_if.TIMEOUT}, 32'd0);
        bus_if.PERIOD_US = {16'd0, 16'd10, 16'd10};
        wait_until(s + 5);
        rst_n = 1'b1;
        ft = next_tick(cyc + 2);
        // last grant restarts at ch2, so ch0 then ch1.
        expect_start(3'b001, ft + 26 * 9 + 2, "post reset ch0"); do_done(3'b001, "post reset ch0");
        expect_start(3'b010, ft + 26 * 9 + 6, "post reset ch1"); do_done(3'b010, "post reset ch1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sensor_poll_scheduler.md
# sensor_poll_scheduler

Schedules periodic sample requests for up to NUM_CH sensor front-ends. Each channel has its own period, counted in 1 µs ticks derived from the 1 MHz divided clock. The block also arbitrates the single shared acquisition bus between channels with a round-robin grant/done handshake. It sits between the 26 MHz→1 MHz divider and the sensor interface controllers, in the 26 MHz domain.

## Interface
- NUM_CH, 3: number of requesting channels, 2..4.
- PER_W, 16: width of each per-channel period field, in µs.
- TMO_US, 200: DONE timeout in µs ticks.
- CLK_26MHZ_IN  in  1  system clock, 26 MHz.
- RESET  in  1  asynchronous, active-low reset.
- CLK_1MHZ_IN  in  1  1 MHz square wave from the divider; registered in the same 26 MHz domain.
- ENABLE  in  1  global scheduling enable.
- PERIOD_US  in  NUM_CH*PER_W  packed periods; channel i is at [i*PER_W +: PER_W]; 0 disables the channel.
- DONE  in  1  single-cycle pulse: the granted channel finished its bus access.
- CLEAR_FLAGS  in  1  single-cycle pulse: clears OVERRUN and TIMEOUT.
- GRANT  out  NUM_CH  one-hot; held for the whole bus access.
- START  out  NUM_CH  one-hot single-cycle pulse in the first GRANT cycle.
- OVERRUN  out  NUM_CH  sticky: a period elapsed while that channel was still pending.
- TIMEOUT  out  NUM_CH  sticky: an access was aborted because DONE never arrived.

## Operation
- **Tick generation:** register CLK_1MHZ_IN. tick = current & ~previous, which gives one 26 MHz cycle per µs.
- **Per-channel counters (PER_W bits):**
  - On tick, if cnt == PERIOD_US-1, cnt wraps to 0 and due[i] pulses; otherwise cnt increments.
  - If PERIOD_US changes below the current cnt, the next tick wraps the counter and fires due.
  - PERIOD_US == 0: cnt held at 0, pending cleared, no due.
- **Pending:**
  - due sets pending[i].
  - If pending[i] is already set and no ISSUE of i happens that cycle, OVERRUN[i] is also set; the request is not queued twice.
- **Arbiter FSM:**
  - IDLE: if any pending bit is set, pick the first set bit after last_grant (circular) → ISSUE.
  - ISSUE (1 cycle): GRANT and START asserted for the chosen channel; clear its pending; last_grant updated → BUSY.
  - BUSY: GRANT held. DONE → RELEASE. If TMO_US ticks elapse without DONE, set TIMEOUT[i] → RELEASE.
  - RELEASE (1 cycle): GRANT low → IDLE.
- **Simultaneous events:**
  - due[i] in the same cycle as ISSUE of channel i: pending[i] stays set, no overrun.
  - DONE arriving in ISSUE or IDLE is ignored.
  - DONE on the same cycle as the timeout expiry counts as DONE; no TIMEOUT.
  - CLEAR_FLAGS on the same cycle as a flag set: the set wins.
- **ENABLE low:**
  - Counters reset to 0, pending cleared, no new ISSUE.
  - An access already in BUSY completes normally through DONE or timeout.
  - When ENABLE rises, the first due for each channel comes PERIOD_US ticks later.
- **Reset (asynchronous, any state):**
  - FSM to IDLE; counters, pending, GRANT, START, OVERRUN and TIMEOUT all 0.
  - last_grant = NUM_CH-1, so channel 0 wins the first arbitration.
  - Previous-tick register resets to 1, so there is no spurious tick on release.

## Timing
- CLK_1MHZ_IN rising seen in cycle n → tick in n+1 → counter and due update at the end of n+1 → pending visible in n+2.
- Pending visible in IDLE at cycle k → ISSUE (GRANT, START) in k+1 → BUSY from k+2.
- DONE sampled in BUSY at cycle m → RELEASE in m+1 (GRANT low) → IDLE in m+2 → earliest next ISSUE in m+3.
- Minimum back-to-back gap: 2 cycles with GRANT low between accesses.
- Timeout counting starts on the first tick after ISSUE. Abort happens within TMO_US µs +1 tick.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset release with PERIOD_US = {0, 25, 10} (ch2, ch1, ch0) and ENABLE=1 → first START[0] on the 10th tick (+2 cycles); START[1] on the 25th tick; ch2 never granted. Repeat every 10 µs and 25 µs respectively.
- ch0 and ch1 both pending in the same IDLE cycle after reset → GRANT order 0 then 1. With both pending again later, the order continues round-robin from 1, so ch0 next only if ch2 is not pending.
- Hold DONE off for ch0 with period 10 → pending re-sets at +10 µs and OVERRUN[0] sets at +20 µs. TIMEOUT[0] sets after 200 ticks; GRANT drops, then ch0 is re-granted. CLEAR_FLAGS → both flags 0.
- DONE pulse on the exact cycle of timeout expiry → TIMEOUT stays 0, RELEASE as normal. A stray DONE while IDLE → no state change.
- ENABLE dropped mid-BUSY → the access finishes on DONE, and no further START. ENABLE raised again → next START exactly PERIOD_US ticks later.
- RESET asserted mid-BUSY → GRANT, START and flags go 0 asynchronously. After release, the FSM is IDLE and last_grant = NUM_CH-1.
